vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE0/H_FP0/H_SYNC0/H_BP0, default 640/16/96/48, mode-0 horizontal timing in pixels.
REQ-002 Parameter V_ACTIVE0/V_FP0/V_SYNC0/V_BP0, default 480/10/2/33, mode-0 vertical timing in lines.
REQ-003 Parameter H_ACTIVE1/H_FP1/H_SYNC1/H_BP1, default 800/40/128/88, mode-1 horizontal timing.
REQ-004 Parameter V_ACTIVE1/V_FP1/V_SYNC1/V_BP1, default 600/1/4/23, mode-1 vertical timing.
REQ-005 Parameter SYNC_POL, default 0, sync active level (0 = active-low, 1 = active-high), both modes.
REQ-006 Parameter DELAY, default 1, legal 1..8, output latency in enabled cycles.
REQ-007 Parameters HCOUNT_W = 11 and VCOUNT_W = 10, counter widths; every H/V total SHALL fit.
REQ-008 clk_in  input  1  single clock for all logic.
REQ-009 rst_in  input  1  reset, synchronous, active-low.
REQ-010 en_in  input  1  pixel-clock enable; low freezes the whole block.
REQ-011 mode_in  input  1  requested timing mode, adopted at frame boundary.
REQ-012 hcount_out  output  HCOUNT_W  pixel column.
REQ-013 vcount_out  output  VCOUNT_W  line number.
REQ-014 hsync_out, vsync_out  output  1 each  sync, level per SYNC_POL.
REQ-015 blank_out  output  1  high outside the active area.
REQ-016 frame_start_out, line_start_out  output  1 each  high when decoded position is (0,0) / hcount 0.
REQ-017 mode_out  output  1  mode in force for the presented pixel.

Function
REQ-018 Internal counters h, v and active mode m SHALL update only on clk_in rising edges with en_in high.
REQ-019 h SHALL increment by 1; at H_TOTAL(m)-1 it SHALL wrap to 0 and v SHALL increment; H_TOTAL = ACTIVE+FP+SYNC+BP.
REQ-020 v SHALL wrap to 0 when h wraps and v = V_TOTAL(m)-1 (frame boundary).
REQ-021 m SHALL load mode_in only on the frame-boundary enabled cycle; mode_in changes elsewhere SHALL be ignored.
REQ-022 hsync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, limits from m; vsync likewise from v.
REQ-023 blank SHALL be 1 iff h >= H_ACTIVE(m) or v >= V_ACTIVE(m).
REQ-024 Decode of (h, v, m) SHALL pass through a DELAY-stage register pipeline; outputs SHALL present the state of DELAY enabled cycles earlier, all outputs mutually aligned.
REQ-025 en_in low SHALL hold counters, m and every pipeline stage; outputs, including frame_start_out/line_start_out, SHALL hold their values.
REQ-026 en_in toggling SHALL never drop, repeat, or misalign a pixel versus continuous enable.
REQ-027 No comparison SHALL depend on width truncation; counters SHALL never exceed TOTAL-1.

Reset
REQ-028 rst_in low at a clock edge SHALL override en_in and set h = 0, v = 0, m = 0, clearing every pipeline stage.
REQ-029 During and after reset until new data propagates, outputs SHALL be: hcount_out 0, vcount_out 0, hsync_out/vsync_out inactive (= ~SYNC_POL), blank_out 1, frame_start_out 0, line_start_out 0, mode_out 0.
REQ-030 First enabled cycle after rst_in rises SHALL count from (0,0); frame_start_out SHALL rise DELAY enabled cycles after that (first decode of (0,0)).
REQ-031 Reset mid-frame or mid-mode-switch SHALL discard the pending state; mode 0 resumes.

Verification
REQ-032 Defaults, en_in=1, reset release -> hsync_out low for h 656..751, frame_start_out period 420000 cycles, blank_out low 640 of 800 cycles on lines 0..479.
REQ-033 mode_in 0->1 at v=100 -> mode-0 timing to frame end; next frame 1056x628, mode_out rises with frame_start_out.
REQ-034 en_in 1-of-4 random gating -> enabled-cycle output stream identical to continuous run; outputs hold when en_in low.
REQ-035 DELAY=4, SYNC_POL=1 -> outputs lag counter decode exactly 4 enabled cycles; hsync_out high for h 656..751.
REQ-036 rst_in low for one cycle at h=799, v=524, mode 1 pending -> outputs at reset values, restart at (0,0), mode 0.
REQ-037 mode_in toggled every cycle -> m equals mode_in sampled on boundary cycle only; frame totals 420000 or 663168 only.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Purpose: VGA raster timing generator with two parameterised modes and a
//          frame-boundary mode switch; decoded position/sync/blank outputs.
// Latency: DELAY enabled cycles from counter state to outputs; en_in low freezes all.
// Ports:   clk_in/rst_in (sync, active-low)/en_in pixel enable/mode_in request;
//          hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
//          frame_start_out, line_start_out, mode_out (all mutually aligned).
module vga_timing_gen #(
  parameter int H_ACTIVE0 = 640,
  parameter int H_FP0     = 16,
  parameter int H_SYNC0   = 96,
  parameter int H_BP0     = 48,
  parameter int V_ACTIVE0 = 480,
  parameter int V_FP0     = 10,
  parameter int V_SYNC0   = 2,
  parameter int V_BP0     = 33,
  parameter int H_ACTIVE1 = 800,
  parameter int H_FP1     = 40,
  parameter int H_SYNC1   = 128,
  parameter int H_BP1     = 88,
  parameter int V_ACTIVE1 = 600,
  parameter int V_FP1     = 1,
  parameter int V_SYNC1   = 4,
  parameter int V_BP1     = 23,
  parameter bit SYNC_POL  = 1'b0,
  parameter int DELAY     = 1,
  parameter int HCOUNT_W  = 11,
  parameter int VCOUNT_W  = 10
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                en_in,
  input  logic                mode_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                blank_out,
  output logic                frame_start_out,
  output logic                line_start_out,
  output logic                mode_out
);

  // Boundaries are stored as "last index" values so that nothing here needs
  // to represent a full total, which may not fit the counter width.
  localparam logic [HCOUNT_W-1:0] H_LAST0 = HCOUNT_W'(H_ACTIVE0 + H_FP0 + H_SYNC0 + H_BP0 - 1);
  localparam logic [HCOUNT_W-1:0] H_LAST1 = HCOUNT_W'(H_ACTIVE1 + H_FP1 + H_SYNC1 + H_BP1 - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST0 = VCOUNT_W'(V_ACTIVE0 + V_FP0 + V_SYNC0 + V_BP0 - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST1 = VCOUNT_W'(V_ACTIVE1 + V_FP1 + V_SYNC1 + V_BP1 - 1);

  localparam logic [HCOUNT_W-1:0] H_ACT0 = HCOUNT_W'(H_ACTIVE0);
  localparam logic [HCOUNT_W-1:0] H_ACT1 = HCOUNT_W'(H_ACTIVE1);
  localparam logic [VCOUNT_W-1:0] V_ACT0 = VCOUNT_W'(V_ACTIVE0);
  localparam logic [VCOUNT_W-1:0] V_ACT1 = VCOUNT_W'(V_ACTIVE1);

  // Sync window as [first, last]; a zero-width sync gives last < first.
  localparam logic [HCOUNT_W-1:0] H_SF0 = HCOUNT_W'(H_ACTIVE0 + H_FP0);
  localparam logic [HCOUNT_W-1:0] H_SL0 = HCOUNT_W'(H_ACTIVE0 + H_FP0 + H_SYNC0 - 1);
  localparam logic [HCOUNT_W-1:0] H_SF1 = HCOUNT_W'(H_ACTIVE1 + H_FP1);
  localparam logic [HCOUNT_W-1:0] H_SL1 = HCOUNT_W'(H_ACTIVE1 + H_FP1 + H_SYNC1 - 1);
  localparam logic [VCOUNT_W-1:0] V_SF0 = VCOUNT_W'(V_ACTIVE0 + V_FP0);
  localparam logic [VCOUNT_W-1:0] V_SL0 = VCOUNT_W'(V_ACTIVE0 + V_FP0 + V_SYNC0 - 1);
  localparam logic [VCOUNT_W-1:0] V_SF1 = VCOUNT_W'(V_ACTIVE1 + V_FP1);
  localparam logic [VCOUNT_W-1:0] V_SL1 = VCOUNT_W'(V_ACTIVE1 + V_FP1 + V_SYNC1 - 1);

  typedef struct packed {
    logic [HCOUNT_W-1:0] h;
    logic [VCOUNT_W-1:0] v;
    logic                hs;
    logic                vs;
    logic                blank;
    logic                fs;
    logic                ls;
    logic                m;
  } pix_t;

  localparam pix_t PIX_RST = '{h: '0, v: '0, hs: ~SYNC_POL, vs: ~SYNC_POL,
                               blank: 1'b1, fs: 1'b0, ls: 1'b0, m: 1'b0};

  logic [HCOUNT_W-1:0] h_q, h_d;
  logic [VCOUNT_W-1:0] v_q, v_d;
  logic                m_q, m_d;

  logic [HCOUNT_W-1:0] h_last, h_act, h_sf, h_sl;
  logic [VCOUNT_W-1:0] v_last, v_act, v_sf, v_sl;
  logic                hs_act, vs_act;
  pix_t                dec_d;
  pix_t                pipe_q [DELAY];

  // All limits follow the mode currently in force, so a frame always
  // completes with the timing it started with.
  always_comb begin
    h_last = m_q ? H_LAST1 : H_LAST0;
    v_last = m_q ? V_LAST1 : V_LAST0;
    h_act  = m_q ? H_ACT1  : H_ACT0;
    v_act  = m_q ? V_ACT1  : V_ACT0;
    h_sf   = m_q ? H_SF1   : H_SF0;
    h_sl   = m_q ? H_SL1   : H_SL0;
    v_sf   = m_q ? V_SF1   : V_SF0;
    v_sl   = m_q ? V_SL1   : V_SL0;
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    m_d = m_q;
    if (en_in) begin
      if (h_q == h_last) begin
        h_d = '0;
        if (v_q == v_last) begin
          v_d = '0;
          m_d = mode_in;  // mode is only adopted on the frame-boundary cycle
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_comb begin
    hs_act      = (h_q >= h_sf) && (h_q <= h_sl);
    vs_act      = (v_q >= v_sf) && (v_q <= v_sl);
    dec_d       = PIX_RST;
    dec_d.h     = h_q;
    dec_d.v     = v_q;
    dec_d.hs    = SYNC_POL ? hs_act : ~hs_act;
    dec_d.vs    = SYNC_POL ? vs_act : ~vs_act;
    dec_d.blank = (h_q >= h_act) || (v_q >= v_act);
    dec_d.fs    = (h_q == '0) && (v_q == '0);
    dec_d.ls    = (h_q == '0);
    dec_d.m     = m_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      h_q <= '0;
      v_q <= '0;
      m_q <= 1'b0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      m_q <= m_d;
    end
  end

  // Every stage advances only with en_in so disabled cycles never insert,
  // drop or repeat a pixel in the output stream.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DELAY; i++) pipe_q[i] <= PIX_RST;
    end else if (en_in) begin
      pipe_q[0] <= dec_d;
      for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    hcount_out      = pipe_q[DELAY-1].h;
    vcount_out      = pipe_q[DELAY-1].v;
    hsync_out       = pipe_q[DELAY-1].hs;
    vsync_out       = pipe_q[DELAY-1].vs;
    blank_out       = pipe_q[DELAY-1].blank;
    frame_start_out = pipe_q[DELAY-1].fs;
    line_start_out  = pipe_q[DELAY-1].ls;
    mode_out        = pipe_q[DELAY-1].m;
  end

endmodule
